// File: rtl/score_manager_pkg.sv
// Shared game definitions for the score manager.
//   - NUM_SCORE_DIGITS : number of BCD digits in a score
//   - bcd_digit_t      : one BCD digit
//   - score_t          : packed BCD score, digit 0 = ones
//   - evt_t            : one cycle's worth of scoring events
//   - to_bcd           : elaboration-time integer to BCD conversion
//   - bcd_gt           : BCD magnitude compare, most significant digit first
package score_manager_pkg;

  localparam int NUM_SCORE_DIGITS   = 5;
  localparam int DEF_PELLET_PTS     = 10;
  localparam int DEF_POWER_PTS      = 50;
  localparam int DEF_GHOST_BASE_PTS = 200;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_SCORE_DIGITS-1:0] score_t;

  typedef struct packed {
    logic pellet;
    logic power;
    logic ghost;
  } evt_t;

  localparam score_t SCORE_ZERO = '0;
  localparam score_t SCORE_MAX  = 20'h99999;

  // Only used on constants (addend table); never on live datapath values.
  function automatic score_t to_bcd(input int unsigned v);
    score_t      r;
    int unsigned t;
    t = v;
    for (int i = 0; i < NUM_SCORE_DIGITS; i++) begin
      r[i] = bcd_digit_t'(t % 10);
      t    = t / 10;
    end
    return r;
  endfunction

  function automatic logic bcd_gt(input score_t a, input score_t b);
    logic gt, done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = NUM_SCORE_DIGITS-1; i >= 0; i--) begin
      if (!done && a[i] != b[i]) begin
        gt   = (a[i] > b[i]);
        done = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_manager_bcd_adder.sv
// Single BCD digit adder (combinational).
//   digit_i  : current score digit (0-9)
//   addend_i : addend digit (0-9)
//   carry_i  : decimal carry in
//   sum_o    : result digit (0-9)
//   carry_o  : decimal carry out
module bcd_digit_adder
  import score_manager_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  bcd_digit_t addend_i,
  input  logic       carry_i,
  output bcd_digit_t sum_o,
  output logic       carry_o
);

  logic [4:0] raw;

  always_comb begin
    raw     = {1'b0, digit_i} + {1'b0, addend_i} + {4'b0, carry_i};
    sum_o   = raw[3:0];
    carry_o = 1'b0;
    // raw tops out at 19, so one subtraction of ten is enough
    if (raw > 5'd9) begin
      sum_o   = 4'(raw - 5'd10);
      carry_o = 1'b1;
    end
  end

endmodule

// File: rtl/score_manager.sv
// Arcade score manager: BCD score accumulation, ghost combo, high score.
//   clk, resetN                 : clock, async active-low reset
//   game_started, is_frightened : level inputs
//   pellet_eaten, power_pellet_eaten, ghost_eaten : single-cycle event pulses
//   ones..ten_thousands         : current score digits (registered)
//   high_score                  : packed BCD high score (registered)
//   ghost_combo                 : ghosts eaten this frightened period, sat 3
//   new_high_score              : current game beat the stored high score
module score_manager
  import score_manager_pkg::*;
#(
  parameter int PELLET_PTS     = DEF_PELLET_PTS,
  parameter int POWER_PTS      = DEF_POWER_PTS,
  parameter int GHOST_BASE_PTS = DEF_GHOST_BASE_PTS
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        game_started,
  input  logic        is_frightened,
  input  logic        pellet_eaten,
  input  logic        power_pellet_eaten,
  input  logic        ghost_eaten,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands,
  output logic [3:0]  ten_thousands,
  output logic [19:0] high_score,
  output logic [1:0]  ghost_combo,
  output logic        new_high_score
);

  score_t     score_q, score_d;
  score_t     high_q, high_d;
  logic [1:0] combo_q, combo_d;
  logic       nhs_q, nhs_d;
  logic       game_q, fright_q;
  // Start edges are only honoured once game_started has been seen low after
  // reset, so a game already running at reset release is not a new game.
  logic       arm_q;

  logic       start_edge, fright_fall;
  evt_t       evt;
  logic       evt_any;

  assign start_edge  = game_started & ~game_q & arm_q;
  assign fright_fall = ~is_frightened & fright_q;

  // Events count only during a game and never in the start-edge cycle.
  always_comb begin
    evt        = '0;
    if (game_started && !start_edge) begin
      evt.pellet = pellet_eaten;
      evt.power  = power_pellet_eaten;
      evt.ghost  = ghost_eaten;
    end
  end
  assign evt_any = evt.pellet | evt.power | evt.ghost;

  // Addend table indexed by {pellet, power, ghost, combo}: every combination
  // is converted to BCD at elaboration so no runtime binary->BCD is needed.
  score_t     add_lut [32];
  score_t     addend;

  for (genvar k = 0; k < 32; k++) begin : g_lut
    localparam int unsigned PTS =
        (((k >> 4) & 1) != 0 ? PELLET_PTS : 0) +
        (((k >> 3) & 1) != 0 ? POWER_PTS  : 0) +
        (((k >> 2) & 1) != 0 ? (GHOST_BASE_PTS << (k & 3)) : 0);
    assign add_lut[k] = to_bcd(PTS);
  end

  assign addend = add_lut[{evt.pellet, evt.power, evt.ghost, combo_q}];

  // Digit-wise ripple; carry out of the top digit means overflow.
  score_t                    sum;
  logic [NUM_SCORE_DIGITS:0] carry;

  assign carry[0] = 1'b0;
  for (genvar i = 0; i < NUM_SCORE_DIGITS; i++) begin : g_dig
    bcd_digit_adder u_add (
      .digit_i  (score_q[i]),
      .addend_i (addend[i]),
      .carry_i  (carry[i]),
      .sum_o    (sum[i]),
      .carry_o  (carry[i+1])
    );
  end

  always_comb begin
    score_d = score_q;
    if (start_edge)   score_d = SCORE_ZERO;
    else if (evt_any) score_d = carry[NUM_SCORE_DIGITS] ? SCORE_MAX : sum;
  end

  // Ghost scored above at the pre-update combo; power clear wins over increment.
  always_comb begin
    combo_d = combo_q;
    if (start_edge) begin
      combo_d = 2'd0;
    end else begin
      if (evt.ghost && combo_q != 2'd3) combo_d = combo_q + 2'd1;
      if (fright_fall || evt.power)     combo_d = 2'd0;
    end
  end

  // High score follows the registered score one cycle later.
  always_comb begin
    high_d = high_q;
    nhs_d  = nhs_q;
    if (start_edge) begin
      nhs_d = 1'b0;
    end else if (bcd_gt(score_q, high_q)) begin
      high_d = score_q;
      nhs_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q  <= SCORE_ZERO;
      high_q   <= SCORE_ZERO;
      combo_q  <= 2'd0;
      nhs_q    <= 1'b0;
      game_q   <= 1'b0;
      fright_q <= 1'b0;
      arm_q    <= 1'b0;
    end else begin
      score_q  <= score_d;
      high_q   <= high_d;
      combo_q  <= combo_d;
      nhs_q    <= nhs_d;
      game_q   <= game_started;
      fright_q <= is_frightened;
      arm_q    <= arm_q | ~game_started;
    end
  end

  assign ones           = score_q[0];
  assign tens           = score_q[1];
  assign hundreds       = score_q[2];
  assign thousands      = score_q[3];
  assign ten_thousands  = score_q[4];
  assign high_score     = high_q;
  assign ghost_combo    = combo_q;
  assign new_high_score = nhs_q;

endmodule

// File: tb/tb_score_manager.sv
// Directed bench for score_manager; expected values are hand-computed BCD.
module tb_score_manager;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        game_started = 1'b0;
  logic        is_frightened = 1'b0;
  logic        pellet_eaten = 1'b0;
  logic        power_pellet_eaten = 1'b0;
  logic        ghost_eaten = 1'b0;
  logic [3:0]  ones, tens, hundreds, thousands, ten_thousands;
  logic [19:0] high_score;
  logic [1:0]  ghost_combo;
  logic        new_high_score;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  score_manager dut (
    .clk                (clk),
    .resetN             (resetN),
    .game_started       (game_started),
    .is_frightened      (is_frightened),
    .pellet_eaten       (pellet_eaten),
    .power_pellet_eaten (power_pellet_eaten),
    .ghost_eaten        (ghost_eaten),
    .ones               (ones),
    .tens               (tens),
    .hundreds           (hundreds),
    .thousands          (thousands),
    .ten_thousands      (ten_thousands),
    .high_score         (high_score),
    .ghost_combo        (ghost_combo),
    .new_high_score     (new_high_score)
  );

  function automatic logic [19:0] score();
    return {ten_thousands, thousands, hundreds, tens, ones};
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Drive one cycle of events from a negedge; outputs are sampled at the next
  // negedge, i.e. after the capturing posedge.
  task automatic pulse(input logic p, input logic w, input logic g);
    pellet_eaten       = p;
    power_pellet_eaten = w;
    ghost_eaten        = g;
    @(negedge clk);
    pellet_eaten       = 1'b0;
    power_pellet_eaten = 1'b0;
    ghost_eaten        = 1'b0;
  endtask

  initial begin
    #1 resetN = 1'b0;
    cyc(); cyc();
    chk("rst_score", score(), 20'h00000);
    chk("rst_high",  high_score, 20'h00000);
    chk("rst_combo", {18'b0, ghost_combo}, 20'h0);
    chk("rst_nhs",   {19'b0, new_high_score}, 20'h0);
    resetN = 1'b1;
    cyc();

    // Game A: three pellets, each visible one cycle later
    game_started = 1'b1;
    cyc();
    chk("a_start", score(), 20'h00000);
    pulse(1, 0, 0); chk("a_p1", score(), 20'h00010);
    pulse(1, 0, 0); chk("a_p2", score(), 20'h00020);
    pulse(1, 0, 0); chk("a_p3", score(), 20'h00030);
    repeat (47) pulse(1, 0, 0);
    chk("a_500", score(), 20'h00500);
    game_started = 1'b0;
    cyc();
    chk("a_high", high_score, 20'h00500);
    chk("a_nhs",  {19'b0, new_high_score}, 20'h1);
    pulse(1, 0, 0);
    chk("a_hold", score(), 20'h00500);

    // Game B: pellet in the start-edge cycle is not scored
    game_started = 1'b1;
    pulse(1, 0, 0);
    chk("b_clear",    score(), 20'h00000);
    chk("b_high_kept", high_score, 20'h00500);
    chk("b_nhs_clr",  {19'b0, new_high_score}, 20'h0);
    repeat (50) pulse(1, 0, 0);
    cyc();
    chk("b_eq_high", high_score, 20'h00500);
    chk("b_eq_nhs",  {19'b0, new_high_score}, 20'h0);
    pulse(1, 0, 0);
    chk("b_510",      score(), 20'h00510);
    chk("b_high_lag", high_score, 20'h00500);
    cyc();
    chk("b_high_510", high_score, 20'h00510);
    chk("b_nhs_set",  {19'b0, new_high_score}, 20'h1);

    // Frightened sequence
    is_frightened = 1'b1;
    pulse(0, 1, 0); chk("f_pow", score(), 20'h00560);
    pulse(0, 0, 1); chk("f_g1",  score(), 20'h00760);
    pulse(0, 0, 1); chk("f_g2",  score(), 20'h01160);
    pulse(0, 0, 1); chk("f_g3",  score(), 20'h01960);
    pulse(0, 0, 1); chk("f_g4",  score(), 20'h03560);
    pulse(0, 0, 1); chk("f_g5",  score(), 20'h05160);
    chk("f_combo3", {18'b0, ghost_combo}, 20'h3);
    is_frightened = 1'b0;
    cyc();
    chk("f_fall", {18'b0, ghost_combo}, 20'h0);

    // Same-cycle power + ghost at combo 2
    is_frightened = 1'b1;
    pulse(0, 1, 0); chk("pg_pow", score(), 20'h05210);
    pulse(0, 0, 1); chk("pg_g1",  score(), 20'h05410);
    pulse(0, 0, 1); chk("pg_g2",  score(), 20'h05810);
    chk("pg_combo2", {18'b0, ghost_combo}, 20'h2);
    pulse(0, 1, 1); chk("pg_both", score(), 20'h06660);
    chk("pg_combo0", {18'b0, ghost_combo}, 20'h0);

    // Asynchronous reset mid-game
    #2 resetN = 1'b0;
    #1;
    chk("mr_score", score(), 20'h00000);
    chk("mr_high",  high_score, 20'h00000);
    chk("mr_nhs",   {19'b0, new_high_score}, 20'h0);
    @(negedge clk);
    is_frightened = 1'b0;
    resetN = 1'b1;
    // game_started still high: no start edge, so this pellet counts
    pulse(1, 0, 0);
    chk("mr_noedge", score(), 20'h00010);

    // Game C: carry through tens, hundreds, thousands
    game_started = 1'b0;
    cyc();
    game_started = 1'b1;
    cyc();
    chk("c_clear", score(), 20'h00000);
    repeat (99) pulse(1, 0, 0);
    chk("c_990", score(), 20'h00990);
    pulse(0, 1, 0);
    chk("c_1040", score(), 20'h01040);
    chk("c_thou", {16'b0, thousands}, 20'h1);

    // Game D: saturation
    game_started = 1'b0;
    cyc();
    game_started = 1'b1;
    cyc();
    is_frightened = 1'b1;
    repeat (3) pulse(0, 0, 1);
    chk("d_1400", score(), 20'h01400);
    repeat (61) pulse(0, 0, 1);
    chk("d_99000", score(), 20'h99000);
    chk("d_combo_sat", {18'b0, ghost_combo}, 20'h3);
    repeat (98) pulse(1, 0, 0);
    chk("d_99980", score(), 20'h99980);
    is_frightened = 1'b0;
    cyc();
    chk("d_combo0", {18'b0, ghost_combo}, 20'h0);
    pulse(0, 0, 1);
    chk("d_sat", score(), 20'h99999);
    pulse(1, 0, 0);
    chk("d_sat_hold", score(), 20'h99999);
    cyc();
    chk("d_high", high_score, 20'h99999);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
